// File: rtl/seq_checker.sv
// rtl/seq_checker.sv - Registered checker for an incrementing count stream with mismatch statistics.
module seq_checker #(
    parameter int NUM_TESTS = 100,
    parameter int WIDTH     = 8,
    parameter int ERR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [15:0]          first_err_idx,
    output logic [WIDTH-1:0]     first_err_exp,
    output logic [WIDTH-1:0]     first_err_got
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0]          LAST_IDX = 16'(NUM_TESTS - 1);
    localparam logic [15:0]          IDX_ONE  = 16'd1;
    localparam logic [WIDTH-1:0]     EXP_ONE  = WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0] ERR_ONE  = ERR_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX  = '1;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [15:0]          idx_q, idx_d;
    logic [ERR_WIDTH-1:0] err_q, err_d;
    logic [15:0]          fidx_q, fidx_d;
    logic [WIDTH-1:0]     fexp_q, fexp_d;
    logic [WIDTH-1:0]     fgot_q, fgot_d;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fexp_d  = fexp_q;
        fgot_d  = fgot_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    exp_d   = EXP_ONE;
                    idx_d   = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fexp_d  = '0;
                    fgot_d  = '0;
                end
            end
            ST_RUN: begin
                // in_ready is high throughout RUN, so in_valid alone marks a handshake.
                if (in_valid) begin
                    if (in_data != exp_q) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_ONE;
                        end
                        if (err_q == '0) begin
                            fidx_d = idx_q;
                            fexp_d = exp_q;
                            fgot_d = in_data;
                        end
                    end
                    exp_d = exp_q + EXP_ONE;
                    idx_d = idx_q + IDX_ONE;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            exp_q   <= EXP_ONE;
            idx_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fexp_q  <= fexp_d;
            fgot_q  <= fgot_d;
        end
    end

    // All outputs decode registered state only; nothing combinational from in_valid/in_data.
    assign in_ready      = (state_q == ST_RUN);
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign pass          = (state_q == ST_DONE) && (err_q == '0);
    assign err_count     = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_exp = fexp_q;
    assign first_err_got = fgot_q;

endmodule

// File: tb/tb_seq_checker.sv
// tb/tb_seq_checker.sv - Directed bench for seq_checker across default, narrow-width and saturating configurations.
module tb_seq_checker;

    logic clk;
    logic rst_n;
    logic start_a, start_w, start_s;
    logic in_valid;
    logic [7:0] in_data;

    logic rdy_a, busy_a, done_a, pass_a;
    logic [15:0] err_a, fidx_a;
    logic [7:0] fexp_a, fgot_a;

    logic rdy_w, busy_w, done_w, pass_w;
    logic [15:0] err_w, fidx_w;
    logic [3:0] fexp_w, fgot_w;

    logic rdy_s, busy_s, done_s, pass_s;
    logic [3:0] err_s;
    logic [15:0] fidx_s;
    logic [7:0] fexp_s, fgot_s;

    int checks;
    int failures;
    int k;
    int cyc;

    seq_checker #(.NUM_TESTS(100), .WIDTH(8), .ERR_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_idx(fidx_a), .first_err_exp(fexp_a), .first_err_got(fgot_a)
    );

    seq_checker #(.NUM_TESTS(20), .WIDTH(4), .ERR_WIDTH(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .in_valid(in_valid), .in_data(in_data[3:0]),
        .in_ready(rdy_w), .busy(busy_w), .done(done_w), .pass(pass_w), .err_count(err_w),
        .first_err_idx(fidx_w), .first_err_exp(fexp_w), .first_err_got(fgot_w)
    );

    seq_checker #(.NUM_TESTS(40), .WIDTH(8), .ERR_WIDTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_s), .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .first_err_idx(fidx_s), .first_err_exp(fexp_s), .first_err_got(fgot_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_w  = 1'b0;
        start_s  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_ready", 32'(rdy_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_pass", 32'(pass_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_fidx", 32'(fidx_a), 0);
        chk("rst_fexp", 32'(fexp_a), 0);
        chk("rst_fgot", 32'(fgot_a), 0);

        // Clean run: beats 1..100 back to back.
        pulse_start_a();
        chk("clean_ready", 32'(rdy_a), 1);
        chk("clean_busy", 32'(busy_a), 1);
        for (int i = 1; i <= 100; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            if (i == 100) chk("clean_done_early", 32'(done_a), 0);
            tick();
        end
        in_valid = 1'b0;
        chk("clean_done", 32'(done_a), 1);
        chk("clean_pass", 32'(pass_a), 1);
        chk("clean_err", 32'(err_a), 0);
        chk("clean_ready_off", 32'(rdy_a), 0);
        chk("clean_busy_off", 32'(busy_a), 0);

        // Wrap-around on the 4-bit instance: 1..15, 0, 1..4.
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        chk("wrap_busy", 32'(busy_w), 1);
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i % 16);
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_done", 32'(done_w), 1);
        chk("wrap_pass", 32'(pass_w), 1);
        chk("wrap_err", 32'(err_w), 0);
        chk("a_untouched_err", 32'(err_a), 0);

        // Single error at beat index 37 (value 99 instead of 38).
        pulse_start_a();
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 37) ? 8'd99 : 8'(i + 1);
            tick();
            if (i == 37) chk("single_err_next", 32'(err_a), 1);
        end
        in_valid = 1'b0;
        chk("single_done", 32'(done_a), 1);
        chk("single_pass", 32'(pass_a), 0);
        chk("single_err", 32'(err_a), 1);
        chk("single_fidx", 32'(fidx_a), 37);
        chk("single_fexp", 32'(fexp_a), 38);
        chk("single_fgot", 32'(fgot_a), 99);

        // Restart from DONE clears statistics; run with gaps and an ignored mid-run start.
        pulse_start_a();
        chk("restart_busy", 32'(busy_a), 1);
        chk("restart_err", 32'(err_a), 0);
        chk("restart_fidx", 32'(fidx_a), 0);
        chk("restart_fexp", 32'(fexp_a), 0);
        chk("restart_fgot", 32'(fgot_a), 0);
        k   = 0;
        cyc = 0;
        while (k < 100 && cyc < 1000) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 8'(k + 1);
            start_a  = (cyc == 30);
            chk("gap_not_done", 32'(done_a), 0);
            tick();
            if (in_valid) k++;
            cyc++;
        end
        in_valid = 1'b0;
        start_a  = 1'b0;
        chk("gap_handshakes", 32'(k), 100);
        chk("gap_done", 32'(done_a), 1);
        chk("gap_pass", 32'(pass_a), 1);
        chk("gap_err", 32'(err_a), 0);

        // Beats offered after DONE are not consumed or compared.
        in_valid = 1'b1;
        in_data  = 8'd77;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        chk("post_done_err", 32'(err_a), 0);
        chk("post_done_done", 32'(done_a), 1);

        // Second run expects 1 again, then is abandoned by reset at beat 50 (start also high).
        pulse_start_a();
        for (int i = 1; i <= 49; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            if (i == 1) chk("rerun_first_beat", 32'(err_a), 0);
        end
        in_data = 8'd50;
        rst_n   = 1'b0;
        start_a = 1'b1;
        tick();
        rst_n    = 1'b1;
        start_a  = 1'b0;
        in_valid = 1'b0;
        chk("midrst_ready", 32'(rdy_a), 0);
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_done", 32'(done_a), 0);
        chk("midrst_pass", 32'(pass_a), 0);
        chk("midrst_err", 32'(err_a), 0);
        chk("midrst_fidx", 32'(fidx_a), 0);
        chk("midrst_fexp", 32'(fexp_a), 0);
        chk("midrst_fgot", 32'(fgot_a), 0);
        tick();
        chk("midrst_idle", 32'(busy_a), 0);
        pulse_start_a();
        for (int i = 1; i <= 100; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("after_rst_done", 32'(done_a), 1);
        chk("after_rst_pass", 32'(pass_a), 1);
        chk("after_rst_err", 32'(err_a), 0);

        // Saturation on the 4-bit error counter: every beat wrong.
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 100);
            tick();
            if (i == 15) chk("sat_reach", 32'(err_s), 15);
            if (i == 16) chk("sat_hold", 32'(err_s), 15);
        end
        in_valid = 1'b0;
        chk("sat_done", 32'(done_s), 1);
        chk("sat_err", 32'(err_s), 15);
        chk("sat_fidx", 32'(fidx_s), 0);
        chk("sat_fexp", 32'(fexp_s), 1);
        chk("sat_fgot", 32'(fgot_s), 101);
        chk("sat_pass", 32'(pass_s), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
# seq_checker

Synthesizable, race-free consumer of an incrementing count stream. It accepts one count value per valid/ready handshake, compares it against an internally generated expected sequence 1, 2, 3, … (modulo 2^WIDTH), and counts mismatches over a run of NUM_TESTS beats. It sits directly downstream of the counter producer and replaces the testbench-side checker that samples on the same clock edge as the producer. All comparison and sampling are registered, so the result does not depend on simulation order.

## Interface

Parameters:
- NUM_TESTS, 100: beats per run; valid range 1 to 2^16-1.
- WIDTH, 8: width of the count data.
- ERR_WIDTH, 16: width of the mismatch counter; the counter saturates.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- rst_n  in  1  Synchronous reset, active low.
- start  in  1  Single-cycle pulse that begins a run; honoured in IDLE and DONE only.
- in_valid  in  1  Producer has a beat on in_data.
- in_data  in  WIDTH  Count value from the producer.
- in_ready  out  1  Checker accepts a beat; high exactly when state is RUN.
- busy  out  1  High in RUN.
- done  out  1  High in DONE; stays high until start or reset.
- pass  out  1  Valid while done is high; 1 when err_count == 0.
- err_count  out  ERR_WIDTH  Number of mismatches in the current or last run.
- first_err_idx  out  16  Beat index (0-based) of the first mismatch.
- first_err_exp  out  WIDTH  Expected value at the first mismatch.
- first_err_got  out  WIDTH  Received value at the first mismatch.

## Operation

- States: IDLE, RUN, DONE.
- Reset (rst_n == 0 at a clk edge):
  - State returns to IDLE.
  - All outputs clear to 0: in_ready, busy, done, pass, err_count, first_err_*.
  - Internal expected value clears to 1; beat index clears to 0.
  - A reset in the middle of a run abandons the run. No partial result is kept.
- IDLE to RUN on start:
  - expected <= 1, idx <= 0.
  - err_count and first_err_* clear.
  - pass <= 0.
- RUN:
  - A handshake is the condition in_valid && in_ready.
  - On each handshake, compare in_data with expected.
  - On a mismatch, err_count increments, saturating at 2^ERR_WIDTH-1.
  - On the first mismatch of the run (err_count == 0 before the update), capture idx, expected and in_data into first_err_*.
  - After each handshake, expected <= expected + 1. The addition wraps modulo 2^WIDTH: 2^WIDTH-1 is followed by 0.
  - After each handshake, idx <= idx + 1.
  - The handshake with idx == NUM_TESTS-1 moves the state to DONE.
  - If in_valid is low, no state changes. Gaps of any length are legal.
- start while in RUN is ignored.
- DONE:
  - done = 1 and pass = (err_count == 0).
  - in_ready = 0; beats offered by the producer are not consumed.
  - start restarts the checker exactly as IDLE to RUN does.
- Checking uses value equality only. Counts arriving after DONE are never compared.

## Timing

- in_ready and busy are decoded from the state register. in_ready rises in the cycle after start is sampled.
- err_count and first_err_* update on the edge that accepts the beat, so they are visible in the next cycle.
- done and pass rise in the cycle after the last handshake.
- Throughput is one beat per cycle. There are no bubbles inserted between handshakes.
- Outputs have no combinational path from in_valid or in_data.
- Reset has priority over start. Reset and start asserted in the same cycle result in IDLE.

## Test plan

- Clean run, NUM_TESTS=100, WIDTH=8:
  - Stimulus: start, then beats 1..100 on consecutive cycles.
  - Required: done rises 1 cycle after beat 100, pass=1, err_count=0.
- Wrap-around, WIDTH=4, NUM_TESTS=20:
  - Stimulus: beats 1..15, 0, 1, 2, 3, 4.
  - Required: pass=1, err_count=0.
- Single error, NUM_TESTS=100:
  - Stimulus: beat index 37 carries 99 instead of 38; all other beats are correct.
  - Required: err_count=1, first_err_idx=37, first_err_exp=38, first_err_got=99, pass=0.
- Gaps and restart:
  - Stimulus: in_valid toggles with random idle cycles; start is pulsed mid-RUN; after DONE, start is pulsed again.
  - Required: the mid-run start is ignored. The first run ends after exactly NUM_TESTS handshakes. The second start clears err_count and first_err_* and begins a new run expecting 1.
- Reset mid-run:
  - Stimulus: rst_n=0 for one cycle at beat 50, then start, then beats 1..100.
  - Required: all outputs are 0 in the cycle after reset. The new run passes with err_count=0.
- Saturation, ERR_WIDTH=4, NUM_TESTS=40:
  - Stimulus: every beat is wrong.
  - Required: err_count holds at 15, first_err_idx=0, pass=0.
